fwd_hazard_unit: RTL

Parametrised forwarding and load-use hazard unit for the decode (ID) stage of the pipeline. It keeps a shift-register record of the destination register of every in-flight instruction for DEPTH stages past ID. For each ID source operand it selects the youngest in-flight producer to forward from. When that producer is a load whose data is not yet available, it stalls ID and inserts bubbles. It also keeps a saturating stall-cycle counter for performance reporting.

---
 rtl/fwd_hazard_unit.sv | 86 ++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - ID-stage forwarding select and load-use hazard detection
// Tracks in-flight destinations for DEPTH stages; youngest matching producer wins.
module fwd_hazard_unit #(
  parameter int REG_BITS   = 3,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = 2,
  parameter int ZERO_REG   = 0,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_rs_use,
  input  logic                id_rt_use,
  input  logic                id_wr,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                id_load,
  input  logic                flush,
  output logic                stall,
  output logic [SEL_W-1:0]    fwd_rs,
  output logic [SEL_W-1:0]    fwd_rt,
  output logic [CNT_W-1:0]    stall_cnt
);

  logic [DEPTH:1]      ent_v;
  logic [DEPTH:1]      ent_wr;
  logic [DEPTH:1]      ent_ld;
  logic [REG_BITS-1:0] ent_rd [1:DEPTH];

  logic rs_zero, rt_zero, rd_zero;
  logic haz_rs, haz_rt;

  assign rs_zero = (ZERO_REG != 0) && (id_rs == '0);
  assign rt_zero = (ZERO_REG != 0) && (id_rt == '0);
  assign rd_zero = (ZERO_REG != 0) && (id_rd == '0);

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    fwd_rs = '0;
    fwd_rt = '0;
    haz_rs = 1'b0;
    haz_rt = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (ent_v[k] && ent_wr[k] && id_rs_use && !rs_zero && (ent_rd[k] == id_rs)) begin
        fwd_rs = SEL_W'(k);
        haz_rs = ent_ld[k] && (k < LOAD_STAGE);
      end
      if (ent_v[k] && ent_wr[k] && id_rt_use && !rt_zero && (ent_rd[k] == id_rt)) begin
        fwd_rt = SEL_W'(k);
        haz_rt = ent_ld[k] && (k < LOAD_STAGE);
      end
    end
  end

  assign stall = id_valid && !flush && (haz_rs || haz_rt);

  always_ff @(posedge clk) begin
    if (!rst) begin
      ent_v     <= '0;
      ent_wr    <= '0;
      ent_ld    <= '0;
      stall_cnt <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        ent_rd[k] <= '0;
      end
    end else begin
      for (int k = DEPTH; k >= 2; k--) begin
        ent_v[k]  <= ent_v[k-1];
        ent_wr[k] <= ent_wr[k-1];
        ent_ld[k] <= ent_ld[k-1];
        ent_rd[k] <= ent_rd[k-1];
      end
      ent_v[1]  <= id_valid && !stall && !flush;
      ent_wr[1] <= id_wr && !rd_zero;
      ent_ld[1] <= id_load;
      ent_rd[1] <= id_rd;
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule
